// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_pkg : shared widths, reset vector and fetch FSM state encodings   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ifu_pkg;

    localparam int unsigned            c_xlen     = 32;
    localparam logic [c_xlen-1:0]      c_reset_pc = 32'h8000_0000;

    localparam int unsigned            c_state_w   = 2;
    localparam logic [c_state_w-1:0]   c_st_req    = 2'd0;
    localparam logic [c_state_w-1:0]   c_st_wait   = 2'd1;
    localparam logic [c_state_w-1:0]   c_st_out    = 2'd2;
    localparam logic [c_state_w-1:0]   c_st_halted = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ifu_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_pc_reg : fetch PC register with redirect / sequential selection   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int unsigned      XLEN     = c_xlen,
    parameter logic [XLEN-1:0]  RESET_PC = c_reset_pc
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Redirect targets are word aligned by clearing the low two bits.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect_en) begin
            w_pc_next = redirect_pc & ~XLEN'(3);
        end else if (advance) begin
            w_pc_next = r_pc + c_pc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu : instruction fetch unit, one outstanding request, decode buffer  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ifu
    import ifu_pkg::*;
#(
    parameter int unsigned      XLEN     = c_xlen,
    parameter logic [XLEN-1:0]  RESET_PC = c_reset_pc
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic                 r_stale;
    logic                 w_stale_next;
    logic [31:0]          r_out_instr;
    logic [XLEN-1:0]      r_out_pc;
    logic [XLEN-1:0]      r_fetch_count;
    logic [XLEN-1:0]      w_pc;
    logic                 w_req_fire;
    logic                 w_out_fire;
    logic                 w_redirect;
    logic                 w_advance;
    logic                 w_latch;

    // Valid outputs are gated by reset so nothing leaks out before the first edge.
    assign imem_req_valid = rst_n && (r_state == c_st_req) && !halt;
    assign out_valid      = rst_n && (r_state == c_st_out);
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_out_fire     = out_valid && out_ready;
    assign w_redirect     = redirect_valid && (r_state != c_st_halted);

    always_comb begin
        w_state_next = r_state;
        w_stale_next = r_stale;
        w_advance    = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            c_st_req: begin
                if (w_req_fire) begin
                    w_state_next = c_st_wait;
                    w_stale_next = redirect_valid;
                end else if (!redirect_valid && halt) begin
                    w_state_next = c_st_halted;
                end
            end
            c_st_wait: begin
                if (imem_rsp_valid) begin
                    w_stale_next = 1'b0;
                    if (r_stale || redirect_valid) begin
                        w_state_next = c_st_req;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = c_st_out;
                    end
                end else if (redirect_valid) begin
                    w_stale_next = 1'b1;
                end
            end
            c_st_out: begin
                if (redirect_valid) begin
                    w_state_next = c_st_req;
                end else if (out_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = halt ? c_st_halted : c_st_req;
                end
            end
            default: begin
                w_state_next = c_st_halted;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_st_req;
            r_stale       <= 1'b0;
            r_out_instr   <= 32'h0;
            r_out_pc      <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_stale <= w_stale_next;
            if (w_latch) begin
                r_out_instr <= imem_rsp_data;
                r_out_pc    <= w_pc;
            end
            if (w_out_fire) begin
                r_fetch_count <= r_fetch_count + XLEN'(1);
            end
        end
    end

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (w_redirect),
        .redirect_pc (redirect_pc),
        .advance     (w_advance),
        .pc          (w_pc)
    );

    assign imem_req_addr = w_pc;
    assign out_instr     = r_out_instr;
    assign out_pc        = r_out_pc;
    assign halted        = (r_state == c_st_halted);
    assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu : scoreboard bench for the instruction fetch unit              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    ifu #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic        pend_valid;
    logic        pend_stale;
    logic [31:0] pend_addr;
    logic        rsp_auto;
    logic [31:0] exp_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0200) return 32'h0010_0073;
        return {a[11:0], 20'h00013};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: track the outstanding request, score deliveries,
    // then drive the memory response for the following cycle.
    task automatic tick();
        logic        hs;
        logic [63:0] item;
        #1;
        hs = imem_req_valid && imem_req_ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                item = sb_q.pop_front();
                check("deliver", {out_pc, out_instr}, item);
            end
            exp_count++;
        end
        if (!rst_n) begin
            pend_valid = 1'b0;
            exp_count  = 32'h0;
        end else begin
            if (pend_valid && imem_rsp_valid) begin
                if (!pend_stale && !redirect_valid)
                    sb_q.push_back({pend_addr, mem_word(pend_addr)});
                pend_valid = 1'b0;
            end else if (pend_valid && redirect_valid) begin
                pend_stale = 1'b1;
            end
            if (hs) begin
                pend_valid = 1'b1;
                pend_addr  = imem_req_addr;
                pend_stale = redirect_valid;
            end
        end
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid = rsp_auto && pend_valid;
        imem_rsp_data  = (rsp_auto && pend_valid) ? mem_word(pend_addr) : 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        out_ready = 1'b1; rsp_auto = 1'b1;
        pend_valid = 1'b0; pend_stale = 1'b0; pend_addr = 32'h0; exp_count = 32'h0;

        // Reset state
        @(negedge clk);
        tick();
        tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_count", fetch_count, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);

        // First fetch with zero-wait memory
        rst_n = 1'b1;
        #1;
        check("first_addr", imem_req_addr, 32'h8000_0000);
        tick();
        check("wait_no_req", imem_req_valid, 0);
        tick();
        check("lat_out_valid", out_valid, 1);
        check("first_out_pc", out_pc, 32'h8000_0000);
        check("first_out_instr", out_instr, 32'h0000_0013);
        tick();
        check("next_req_valid", imem_req_valid, 1);
        check("next_addr", imem_req_addr, 32'h8000_0004);
        check("count_1", fetch_count, exp_count);

        // Decode backpressure
        out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_pc", out_pc, 32'h8000_0004);
            check("stall_instr", out_instr, 32'h0040_0013);
            check("stall_no_req", imem_req_valid, 0);
            check("stall_count", fetch_count, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("count_2", fetch_count, exp_count);

        // Redirect while waiting for memory
        rsp_auto = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0; rsp_auto = 1'b1;
        #1;
        check("stale_wait", imem_req_valid, 0);
        tick();
        check("stale_no_out", out_valid, 0);
        tick();
        check("drop_no_out", out_valid, 0);
        check("drop_req_valid", imem_req_valid, 1);
        check("redirect_addr", imem_req_addr, 32'h8000_0100);
        tick();
        tick();
        check("redir_out_pc", out_pc, 32'h8000_0100);
        tick();

        // Redirect coincident with the decode handshake
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rc_out_valid", out_valid, 0);
        check("rc_count", fetch_count, exp_count);
        check("rc_addr", imem_req_addr, 32'h8000_0200);

        // Halt on delivery of ebreak
        tick();
        tick();
        check("ebreak_instr", out_instr, 32'h0010_0073);
        halt = 1'b1;
        tick();
        check("halted_set", halted, 1);
        check("halted_no_req", imem_req_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", halted, 1);
            check("halt_no_req", imem_req_valid, 0);
            check("halt_no_out", out_valid, 0);
            check("halt_count", fetch_count, exp_count);
        end
        redirect_valid = 1'b0;

        // Reset pulsed during WAIT, late response afterwards
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_halted", halted, 0);
        check("rst2_addr", imem_req_addr, 32'h8000_0000);
        rsp_auto = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef;
        tick();
        check("late_no_out", out_valid, 0);
        check("late_req_valid", imem_req_valid, 1);
        check("late_addr", imem_req_addr, 32'h8000_0000);
        imem_req_ready = 1'b1; rsp_auto = 1'b1;
        tick();
        tick();
        check("rst2_out_pc", out_pc, 32'h8000_0000);
        check("rst2_out_instr", out_instr, 32'h0000_0013);
        tick();

        // Unaligned redirect to the top of memory, then PC wrap
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hffff_ffff;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        check("align_addr", imem_req_addr, 32'hffff_fffc);
        tick();
        tick();
        check("top_out_pc", out_pc, 32'hffff_fffc);
        tick();
        check("wrap_addr", imem_req_addr, 32'h0000_0000);
        check("wrap_count", fetch_count, exp_count);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 Parameter XLEN, default `XLEN from the shared defines, is the PC/address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 redirect_valid  input  1  PC redirect request from branch/jump resolution.
REQ-006 redirect_pc  input  XLEN  redirect target.
REQ-007 halt  input  1  stop fetching (driven by decoded ebreak).
REQ-008 imem_req_valid  output  1  instruction memory request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  XLEN  fetch address.
REQ-011 imem_rsp_valid  input  1  read data valid.
REQ-012 imem_rsp_data  input  32  fetched instruction word.
REQ-013 out_valid  output  1  instruction available to decode.
REQ-014 out_ready  input  1  decode accepts instruction.
REQ-015 out_instr  output  32  instruction to decode.
REQ-016 out_pc  output  XLEN  PC of out_instr.
REQ-017 halted  output  1  fetch permanently stopped.
REQ-018 fetch_count  output  XLEN  instructions delivered to decode, wraps at 2^XLEN.

Function
REQ-019 FSM states: REQ, WAIT, OUT, HALTED; at most one memory request outstanding.
REQ-020 REQ: imem_req_valid=1 and imem_req_addr=pc unless halt=1; handshake (valid&ready) -> WAIT; halt=1 in REQ -> HALTED with imem_req_valid=0.
REQ-021 WAIT: on imem_rsp_valid, a non-stale response is latched into out_instr/out_pc -> OUT; a stale response is dropped -> REQ.
REQ-022 imem_rsp_valid outside WAIT is ignored.
REQ-023 OUT: out_valid=1, out_instr/out_pc held stable until out_ready; on handshake pc<=pc+4, fetch_count+1, next state REQ, or HALTED if halt=1.
REQ-024 Redirect has highest priority in every state except HALTED: pc<=redirect_pc with bits [1:0] forced to 0.
REQ-025 Redirect in REQ with same-cycle request handshake: the issued request is marked stale, next state WAIT.
REQ-026 Redirect in REQ without handshake: next cycle requests the new pc.
REQ-027 Redirect in WAIT: stale flag set; response dropped; new request follows.
REQ-028 Redirect in OUT, with or without same-cycle out handshake: the buffered instruction is not delivered (if handshake coincides, the delivery counts but pc takes redirect_pc, not pc+4); out_valid=0 next cycle; -> REQ.
REQ-029 pc+4 wraps modulo 2^XLEN.
REQ-030 HALTED: all valid outputs 0, halted=1, redirect ignored; exit only by reset.
REQ-031 Latency: zero-wait memory (ready=1, rsp one cycle after request) gives out_valid two cycles after the request handshake cycle.

Reset
REQ-032 While rst_n=0 at a rising edge: pc=RESET_PC, state=REQ, stale=0, fetch_count=0, out_instr=0, out_pc=0, halted=0; imem_req_valid and out_valid are 0 during reset.
REQ-033 Reset asserted mid-transaction abandons the outstanding request; a late response after reset is ignored (state REQ).

Structure
REQ-034 XLEN, RESET_PC default and FSM state encodings reside in the shared defines file.
REQ-035 PC register with next-pc selection is one natural sub-module: pc_reg.

Verification
REQ-036 Reset release, ready=1, 1-cycle rsp of 32'h00000013 -> out_valid with out_pc=32'h80000000, out_instr=32'h00000013; next request addr 32'h80000004.
REQ-037 out_ready=0 for 5 cycles -> out_valid/out_instr/out_pc stable, imem_req_valid=0, fetch_count unchanged.
REQ-038 redirect_pc=32'h80000102 during WAIT -> response dropped, next request addr 32'h80000100, no out_valid for stale word.
REQ-039 halt=1 with out handshake of 32'h00100073 -> halted=1 next cycle, no further requests, redirect ignored.
REQ-040 Reset pulsed during WAIT, response arrives one cycle later -> ignored; first request after reset addr 32'h80000000.
REQ-041 Redirect coincident with out handshake -> fetch_count+1, next request addr = redirect target.
